flow_ctrl: RTL and testbench

//  Pipeline flow-control unit; drives the bk (hold) and flush inputs of pc, if_id, id_ex, ex_mem and mem_wb regs.

---
 rtl/fc_pkg.sv | 29 ++
 rtl/flow_ctrl_if.sv | 46 ++++
 rtl/fc_hazard_detect.sv | 25 ++
 rtl/flow_ctrl.sv | 137 +++++++++++++
 tb/tb_flow_ctrl.sv | 178 +++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
// Shared types for the pipeline flow-control unit: FSM encodings, hold/bubble vectors, x0 index.
// No logic; imported by flow_ctrl and its sub-module.
// No flow control of its own.
package fc_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERR      = 2'd2
    } fc_state_e;

    localparam logic [4:0] REG_ZERO = 5'h0;

    typedef struct packed {
        logic pc;
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } fc_bk_t;

    typedef struct packed {
        logic ifid;
        logic idex;
        logic exmem;
        logic memwb;
    } fc_flush_t;

endpackage

// File: rtl/flow_ctrl_if.sv
// Bundle between the pipeline and the flow-control unit: hazard inputs, hold/bubble outputs, counters.
// Pure wiring, zero latency.
// Carries the hold (bk) signals that are the pipeline's backpressure.
interface flow_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs1_raddr_i;
    logic             id_rs1_re_i;
    logic [4:0]       id_rs2_raddr_i;
    logic             id_rs2_re_i;
    logic             idex_mem_re_i;
    logic [4:0]       idex_reg_waddr_i;
    logic             ex_jump_i;
    logic             mem_req_i;
    logic             mem_ack_i;

    logic             fc_bk_pc_o;
    logic             fc_bk_ifid_o;
    logic             fc_bk_idex_o;
    logic             fc_bk_exmem_o;
    logic             fc_bk_memwb_o;
    logic             fc_flush_ifid_o;
    logic             fc_flush_idex_o;
    logic             fc_flush_exmem_o;
    logic             fc_flush_memwb_o;
    logic [CNT_W-1:0] fc_stall_cnt_o;
    logic [CNT_W-1:0] fc_flush_cnt_o;
    logic             fc_err_o;

    modport master (
        output id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
               idex_mem_re_i, idex_reg_waddr_i, ex_jump_i, mem_req_i, mem_ack_i,
        input  fc_bk_pc_o, fc_bk_ifid_o, fc_bk_idex_o, fc_bk_exmem_o, fc_bk_memwb_o,
               fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o,
               fc_stall_cnt_o, fc_flush_cnt_o, fc_err_o
    );

    modport slave (
        input  id_rs1_raddr_i, id_rs1_re_i, id_rs2_raddr_i, id_rs2_re_i,
               idex_mem_re_i, idex_reg_waddr_i, ex_jump_i, mem_req_i, mem_ack_i,
        output fc_bk_pc_o, fc_bk_ifid_o, fc_bk_idex_o, fc_bk_exmem_o, fc_bk_memwb_o,
               fc_flush_ifid_o, fc_flush_idex_o, fc_flush_exmem_o, fc_flush_memwb_o,
               fc_stall_cnt_o, fc_flush_cnt_o, fc_err_o
    );

endinterface

// File: rtl/fc_hazard_detect.sv
// Load-use detector: instr in EX loads a register that the instr in ID reads.
// Combinational, 0 cycles.
// No flow control; the result feeds the hold/bubble mux in flow_ctrl.
module fc_hazard_detect
    import fc_pkg::*;
(
    input  logic [4:0] id_rs1_raddr_i,
    input  logic       id_rs1_re_i,
    input  logic [4:0] id_rs2_raddr_i,
    input  logic       id_rs2_re_i,
    input  logic       idex_mem_re_i,
    input  logic [4:0] idex_reg_waddr_i,
    output logic       hazard_o
);
    logic rs1_hit;
    logic rs2_hit;

    always_comb begin
        rs1_hit  = id_rs1_re_i && (id_rs1_raddr_i == idex_reg_waddr_i);
        rs2_hit  = id_rs2_re_i && (id_rs2_raddr_i == idex_reg_waddr_i);
        // x0 is hardwired zero, so a load targeting it never creates a dependency
        hazard_o = idex_mem_re_i && (idex_reg_waddr_i != REG_ZERO) && (rs1_hit || rs2_hit);
    end

endmodule

// File: rtl/flow_ctrl.sv
// Pipeline hold/bubble generator (mem wait > jump > load-use) with stall/flush counters; FC_TIMEOUT_EN adds a watchdog.
// bk/flush are combinational (0 cycles) from state+inputs; FSM, counters and error flag are registered.
// Memory wait holds pc..ex_mem and bubbles mem_wb until ack; held stages keep lower-priority events pending.
module flow_ctrl
    import fc_pkg::*;
#(
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic       clk,
    input  logic       rst_n,
    flow_ctrl_if.slave fc
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    fc_state_e        state_q, state_d;
    logic             hazard;
    logic             mem_stall;
    logic             err_cyc;
    logic             timeout;
    fc_bk_t           bk_raw, bk;
    fc_flush_t        fl_raw, fl;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    fc_hazard_detect u_hazard (
        .id_rs1_raddr_i   (fc.id_rs1_raddr_i),
        .id_rs1_re_i      (fc.id_rs1_re_i),
        .id_rs2_raddr_i   (fc.id_rs2_raddr_i),
        .id_rs2_re_i      (fc.id_rs2_re_i),
        .idex_mem_re_i    (fc.idex_mem_re_i),
        .idex_reg_waddr_i (fc.idex_reg_waddr_i),
        .hazard_o         (hazard)
    );

`ifdef FC_TIMEOUT_EN
    localparam int                WAIT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              err_q, err_d;

    always_comb begin
        // Restarts from zero on every entry because RUN is the only way into MEM_WAIT
        wait_d  = (state_q == ST_MEM_WAIT) ? wait_q + WAIT_W'(1) : '0;
        err_d   = err_q || err_cyc;
        timeout = (wait_q == WAIT_LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_q <= '0;
            err_q  <= 1'b0;
        end else begin
            wait_q <= wait_d;
            err_q  <= err_d;
        end
    end

    assign fc.fc_err_o = err_q || err_cyc;
`else
    assign timeout     = 1'b0;
    assign fc.fc_err_o = 1'b0;
`endif

    always_comb begin
        mem_stall = 1'b0;
        state_d   = state_q;
        case (state_q)
            ST_RUN: begin
                mem_stall = fc.mem_req_i && !fc.mem_ack_i;
                if (fc.mem_req_i && !fc.mem_ack_i) state_d = ST_MEM_WAIT;
            end
            ST_MEM_WAIT: begin
                mem_stall = !fc.mem_ack_i;
                if (fc.mem_ack_i)  state_d = ST_RUN;
                else if (timeout)  state_d = ST_ERR;
            end
            default: state_d = ST_RUN;
        endcase
        err_cyc = (state_q == ST_ERR);
    end

    always_comb begin
        bk_raw = '0;
        fl_raw = '0;
        if (err_cyc) begin
            fl_raw = '1;
        end else if (mem_stall) begin
            bk_raw.pc    = 1'b1;
            bk_raw.ifid  = 1'b1;
            bk_raw.idex  = 1'b1;
            bk_raw.exmem = 1'b1;
            fl_raw.memwb = 1'b1;
        end else if (fc.ex_jump_i) begin
            fl_raw.ifid  = 1'b1;
            fl_raw.idex  = 1'b1;
        end else if (hazard) begin
            bk_raw.pc    = 1'b1;
            bk_raw.ifid  = 1'b1;
            fl_raw.idex  = 1'b1;
        end
        // A held register must not also load a bubble
        bk = rst_n ? bk_raw : '0;
        fl = rst_n ? (fl_raw & ~{bk.ifid, bk.idex, bk.exmem, bk.memwb}) : '0;
    end

    always_comb begin
        stall_cnt_d = (bk.pc && (stall_cnt_q != CNT_MAX)) ? stall_cnt_q + CNT_W'(1) : stall_cnt_q;
        flush_cnt_d = ((|fl) && (flush_cnt_q != CNT_MAX)) ? flush_cnt_q + CNT_W'(1) : flush_cnt_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign fc.fc_bk_pc_o       = bk.pc;
    assign fc.fc_bk_ifid_o     = bk.ifid;
    assign fc.fc_bk_idex_o     = bk.idex;
    assign fc.fc_bk_exmem_o    = bk.exmem;
    assign fc.fc_bk_memwb_o    = bk.memwb;
    assign fc.fc_flush_ifid_o  = fl.ifid;
    assign fc.fc_flush_idex_o  = fl.idex;
    assign fc.fc_flush_exmem_o = fl.exmem;
    assign fc.fc_flush_memwb_o = fl.memwb;
    assign fc.fc_stall_cnt_o   = stall_cnt_q;
    assign fc.fc_flush_cnt_o   = flush_cnt_q;

endmodule

// File: tb/tb_flow_ctrl.sv
// Bench for flow_ctrl: per-cycle stimulus with expected hold/bubble vectors queued and compared 1ns later.
// Counters and the error flag are checked against values accumulated from the expected vectors.
module tb_flow_ctrl;
    localparam int CNT_W = 4;
    localparam int TO    = 4;
    localparam int MAXC  = (1 << CNT_W) - 1;

    // {bk pc,ifid,idex,exmem,memwb, flush ifid,idex,exmem,memwb}
    localparam logic [8:0] E_NONE = 9'b00000_0000;
    localparam logic [8:0] E_LU   = 9'b11000_0100;
    localparam logic [8:0] E_MEM  = 9'b11110_0001;
    localparam logic [8:0] E_JMP  = 9'b00000_1100;
    localparam logic [8:0] E_ERR  = 9'b00000_1111;

    typedef struct packed {
        logic [4:0] rs1;
        logic       rs1_re;
        logic [4:0] rs2;
        logic       rs2_re;
        logic       ld;
        logic [4:0] rd;
        logic       jmp;
        logic       req;
        logic       ack;
    } stim_t;

    localparam stim_t IDLE = '0;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    int         n_tests = 0;
    int         n_fail  = 0;
    int         exp_stall = 0;
    int         exp_flush = 0;
    logic       exp_err   = 1'b0;
    logic [8:0] sb_q[$];

    flow_ctrl_if #(.CNT_W(CNT_W)) fc_if ();

    flow_ctrl #(.CNT_W(CNT_W), .TIMEOUT_CYCLES(TO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .fc    (fc_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic stim_t S(input logic [4:0] rs1, input logic rs1_re, input logic [4:0] rs2,
                                input logic rs2_re, input logic ld, input logic [4:0] rd,
                                input logic jmp, input logic req, input logic ack);
        stim_t s;
        s = '{rs1, rs1_re, rs2, rs2_re, ld, rd, jmp, req, ack};
        return s;
    endfunction

    function automatic logic [8:0] outs();
        return {fc_if.fc_bk_pc_o, fc_if.fc_bk_ifid_o, fc_if.fc_bk_idex_o, fc_if.fc_bk_exmem_o,
                fc_if.fc_bk_memwb_o, fc_if.fc_flush_ifid_o, fc_if.fc_flush_idex_o,
                fc_if.fc_flush_exmem_o, fc_if.fc_flush_memwb_o};
    endfunction

    function automatic int sat(input int v);
        return (v >= MAXC) ? MAXC : v + 1;
    endfunction

    task automatic drive(input stim_t s);
        fc_if.id_rs1_raddr_i   = s.rs1;
        fc_if.id_rs1_re_i      = s.rs1_re;
        fc_if.id_rs2_raddr_i   = s.rs2;
        fc_if.id_rs2_re_i      = s.rs2_re;
        fc_if.idex_mem_re_i    = s.ld;
        fc_if.idex_reg_waddr_i = s.rd;
        fc_if.ex_jump_i        = s.jmp;
        fc_if.mem_req_i        = s.req;
        fc_if.mem_ack_i        = s.ack;
    endtask

    task automatic step(input string tag, input stim_t s, input logic [8:0] exp);
        logic [8:0] e;
        @(negedge clk);
        chk({tag, "/stall_cnt"}, 32'(fc_if.fc_stall_cnt_o), 32'(exp_stall));
        chk({tag, "/flush_cnt"}, 32'(fc_if.fc_flush_cnt_o), 32'(exp_flush));
        drive(s);
        sb_q.push_back(exp);
        #1;
        e = sb_q.pop_front();
        chk({tag, "/outs"}, 32'(outs()), 32'(e));
        chk({tag, "/err"}, 32'(fc_if.fc_err_o), 32'(exp_err));
        if (e[8])     exp_stall = sat(exp_stall);
        if (|e[3:0])  exp_flush = sat(exp_flush);
    endtask

    // Reset lands mid-cycle with every hazard source active; outputs must still read zero
    task automatic do_reset();
        @(negedge clk);
        drive(S(5'd5, 1'b1, 5'd5, 1'b1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0));
        #2 rst_n = 1'b0;
        #1;
        chk("rst/outs", 32'(outs()), 32'(E_NONE));
        chk("rst/stall_cnt", 32'(fc_if.fc_stall_cnt_o), 32'd0);
        chk("rst/flush_cnt", 32'(fc_if.fc_flush_cnt_o), 32'd0);
        chk("rst/err", 32'(fc_if.fc_err_o), 32'd0);
        @(negedge clk);
        drive(IDLE);
        rst_n     = 1'b1;
        exp_stall = 0;
        exp_flush = 0;
        exp_err   = 1'b0;
    endtask

    initial begin
        drive(IDLE);
        do_reset();

        step("lu_rs1",     S(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0), E_LU);
        step("lu_clear",   IDLE, E_NONE);
        step("lu_rs2",     S(5'd3, 1'b1, 5'd7, 1'b1, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), E_LU);
        step("rs2_no_re",  S(5'd3, 1'b1, 5'd7, 1'b0, 1'b1, 5'd7, 1'b0, 1'b0, 1'b0), E_NONE);
        step("rd_differ",  S(5'd6, 1'b1, 5'd8, 1'b1, 1'b1, 5'd9, 1'b0, 1'b0, 1'b0), E_NONE);
        step("no_load",    S(5'd9, 1'b1, 5'd9, 1'b1, 1'b0, 5'd9, 1'b0, 1'b0, 1'b0), E_NONE);
        step("x0_load",    S(5'd0, 1'b1, 5'd0, 1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0), E_NONE);
        step("x0_after",   IDLE, E_NONE);

        do_reset();
        step("mem_req",    S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), E_MEM);
        step("mem_w_jlu",  S(5'd4, 1'b1, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1, 1'b0, 1'b0), E_MEM);
        step("mem_w_req",  S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), E_MEM);
        step("mem_ack_j",  S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1), E_JMP);
        step("mem_after",  IDLE, E_NONE);
        chk("mem/stall_total", 32'(fc_if.fc_stall_cnt_o), 32'd3);

        step("jmp_lu",     S(5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0), E_JMP);
        step("req_ack",    S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b1), E_NONE);
        step("req_ack_run", IDLE, E_NONE);

        step("wait_enter", S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), E_MEM);
        step("wait_held",  IDLE, E_MEM);
        do_reset();
        step("wait_rst_run", IDLE, E_NONE);

        for (int i = 0; i < 20; i++)
            step("sat_lu", S(5'd1, 1'b1, 5'd0, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b0), E_LU);
        step("sat_end",    IDLE, E_NONE);
        chk("sat/stall_max", 32'(fc_if.fc_stall_cnt_o), 32'(MAXC));
        chk("sat/flush_max", 32'(fc_if.fc_flush_cnt_o), 32'(MAXC));

        do_reset();
`ifdef FC_TIMEOUT_EN
        step("to_req",     S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), E_MEM);
        for (int i = 0; i < TO; i++)
            step("to_wait", IDLE, E_MEM);
        exp_err = 1'b1;
        step("to_err",     IDLE, E_ERR);
        step("to_run",     IDLE, E_NONE);
        step("to_sticky",  IDLE, E_NONE);
        do_reset();
        step("to_cleared", IDLE, E_NONE);
`else
        step("lw_req",     S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0), E_MEM);
        for (int i = 0; i < 10; i++)
            step("lw_wait", IDLE, E_MEM);
        step("lw_ack",     S(5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1), E_NONE);
        step("lw_after",   IDLE, E_NONE);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
